// File: rtl/branch_resolve_ma_pkg.sv
// rtl/branch_resolve_ma_pkg.sv - shared op encodings, FSM states and forward-select constants
package branch_resolve_ma_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BEQ  = 3'b001,
        OP_BNE  = 3'b010,
        OP_BLT  = 3'b011,
        OP_BGE  = 3'b100,
        OP_BLTU = 3'b101,
        OP_BGEU = 3'b110,
        OP_JMP  = 3'b111
    } op_e;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_e;

    localparam int FWD_OWN = 0;

endpackage

// File: rtl/branch_lane_eval.sv
// rtl/branch_lane_eval.sv - one-lane operand forwarding, compare and target selection
module branch_lane_eval
    import branch_resolve_ma_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2,
    parameter int SELW = 2
) (
    input  logic                 enable,
    input  logic [2:0]           op,
    input  logic                 pred_taken,
    input  logic [XLEN-1:0]      srca,
    input  logic [XLEN-1:0]      srcb,
    input  logic [SELW-1:0]      fwda_sel,
    input  logic [SELW-1:0]      fwdb_sel,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic [XLEN-1:0]      pc_plus,
    input  logic [XLEN-1:0]      pc_branch,
    output logic                 resolved,
    output logic                 taken,
    output logic                 mispredict,
    output logic [XLEN-1:0]      actual_pc
);

    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;

    // Select values beyond NFWD fall back to the register-read operand.
    always_comb begin
        opa = srca;
        opb = srcb;
        for (int k = 0; k < NFWD; k++) begin
            if (fwda_sel != SELW'(FWD_OWN) && fwda_sel == SELW'(k + 1))
                opa = fwd_data[k*XLEN +: XLEN];
            if (fwdb_sel != SELW'(FWD_OWN) && fwdb_sel == SELW'(k + 1))
                opb = fwd_data[k*XLEN +: XLEN];
        end
    end

    always_comb begin
        case (op_e'(op))
            OP_BEQ:  taken = (opa == opb);
            OP_BNE:  taken = (opa != opb);
            OP_BLT:  taken = ($signed(opa) <  $signed(opb));
            OP_BGE:  taken = ($signed(opa) >= $signed(opb));
            OP_BLTU: taken = (opa <  opb);
            OP_BGEU: taken = (opa >= opb);
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign resolved   = enable && (op != OP_NONE);
    assign mispredict = resolved && (taken != pred_taken);
    assign actual_pc  = taken ? pc_branch : pc_plus;

endmodule

// File: rtl/branch_resolve_ma.sv
// rtl/branch_resolve_ma.sv - multi-lane branch resolver with oldest-mispredict redirect and squash
module branch_resolve_ma
    import branch_resolve_ma_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int NFWD  = 2,
    parameter int SELW  = 2,
    parameter int CNTW  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic [LANES-1:0]       valid_i,
    input  logic [3*LANES-1:0]     op_i,
    input  logic [LANES-1:0]       link_i,
    input  logic [LANES-1:0]       pred_taken_i,
    input  logic [XLEN*LANES-1:0]  srca_i,
    input  logic [XLEN*LANES-1:0]  srcb_i,
    input  logic [SELW*LANES-1:0]  fwda_sel_i,
    input  logic [SELW*LANES-1:0]  fwdb_sel_i,
    input  logic [XLEN*NFWD-1:0]   fwd_data_i,
    input  logic [XLEN*LANES-1:0]  pc_plus_i,
    input  logic [XLEN*LANES-1:0]  pc_branch_i,
    input  logic [XLEN*LANES-1:0]  cal_result_i,
    output logic [XLEN*LANES-1:0]  write_back_o,
    output logic [LANES-1:0]       kill_o,
    output logic                   redirect_valid_o,
    output logic [XLEN-1:0]        redirect_pc_o,
    output logic                   upd_valid_o,
    output logic                   upd_taken_o,
    output logic [XLEN-1:0]        upd_pc_o,
    output logic [CNTW-1:0]        branch_cnt_o,
    output logic [CNTW-1:0]        mispred_cnt_o
);

    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW   = $clog2(LANES + 1);

    state_e           state;
    logic [LANES-1:0] resolved;
    logic [LANES-1:0] taken;
    logic [LANES-1:0] mispredict;
    logic [XLEN-1:0]  lane_pc [LANES];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        branch_lane_eval #(.XLEN(XLEN), .NFWD(NFWD), .SELW(SELW)) u_eval (
            .enable     (valid_i[g] && state == RUN),
            .op         (op_i[g*3 +: 3]),
            .pred_taken (pred_taken_i[g]),
            .srca       (srca_i[g*XLEN +: XLEN]),
            .srcb       (srcb_i[g*XLEN +: XLEN]),
            .fwda_sel   (fwda_sel_i[g*SELW +: SELW]),
            .fwdb_sel   (fwdb_sel_i[g*SELW +: SELW]),
            .fwd_data   (fwd_data_i),
            .pc_plus    (pc_plus_i[g*XLEN +: XLEN]),
            .pc_branch  (pc_branch_i[g*XLEN +: XLEN]),
            .resolved   (resolved[g]),
            .taken      (taken[g]),
            .mispredict (mispredict[g]),
            .actual_pc  (lane_pc[g])
        );
        assign write_back_o[g*XLEN +: XLEN] = link_i[g] ? pc_plus_i[g*XLEN +: XLEN]
                                                        : cal_result_i[g*XLEN +: XLEN];
    end

    logic            found;
    logic            res_found;
    logic [IDXW-1:0] mis_idx;
    logic [IDXW-1:0] upd_idx;
    logic [CW-1:0]   res_cnt;

    // Walk oldest to youngest; everything after the first mispredict is wrong-path.
    always_comb begin
        found     = 1'b0;
        res_found = 1'b0;
        mis_idx   = '0;
        upd_idx   = '0;
        res_cnt   = '0;
        kill_o    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (found) begin
                kill_o[i] = 1'b1;
            end else begin
                if (resolved[i]) res_cnt = res_cnt + CW'(1);
                if (resolved[i] && !res_found) begin
                    res_found = 1'b1;
                    upd_idx   = IDXW'(i);
                end
                if (mispredict[i]) begin
                    found   = 1'b1;
                    mis_idx = IDXW'(i);
                end
            end
        end
    end

    logic [CNTW:0] bsum;
    assign bsum = {1'b0, branch_cnt_o} + (CNTW+1)'(res_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            upd_valid_o      <= 1'b0;
            upd_taken_o      <= 1'b0;
            upd_pc_o         <= '0;
            branch_cnt_o     <= '0;
            mispred_cnt_o    <= '0;
        end else if (!stall_i) begin
            redirect_valid_o <= found;
            redirect_pc_o    <= found ? lane_pc[mis_idx] : '0;
            upd_valid_o      <= res_found;
            upd_taken_o      <= res_found && taken[upd_idx];
            upd_pc_o         <= res_found ? pc_plus_i[upd_idx*XLEN +: XLEN] - XLEN'(4) : '0;
            branch_cnt_o     <= bsum[CNTW] ? '1 : bsum[CNTW-1:0];
            if (found && mispred_cnt_o != '1)
                mispred_cnt_o <= mispred_cnt_o + CNTW'(1);
            case (state)
                RUN:     if (found) state <= SQUASH;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_ma.sv
// tb/tb_branch_resolve_ma.sv - randomized and directed self-checking bench against a reference model
module tb_branch_resolve_ma;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int NFWD  = 2;
    localparam int SELW  = 2;
    localparam int CNTW  = 4;
    localparam int CMAX  = 15;

    logic                  clk = 1'b0;
    logic                  rst, stall;
    logic [LANES-1:0]      valid_p, link_p, pred_p;
    logic [3*LANES-1:0]    op_p;
    logic [XLEN*LANES-1:0] srca_p, srcb_p, pcp_p, pcb_p, cal_p;
    logic [SELW*LANES-1:0] fas_p, fbs_p;
    logic [XLEN*NFWD-1:0]  fwd_p;
    logic [XLEN*LANES-1:0] wb;
    logic [LANES-1:0]      kill;
    logic                  rv, uv, ut;
    logic [XLEN-1:0]       rpc, upc;
    logic [CNTW-1:0]       bcnt, mcnt;

    always #5 clk = ~clk;

    branch_resolve_ma #(.LANES(LANES), .XLEN(XLEN), .NFWD(NFWD), .SELW(SELW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .valid_i(valid_p), .op_i(op_p), .link_i(link_p),
        .pred_taken_i(pred_p), .srca_i(srca_p), .srcb_i(srcb_p), .fwda_sel_i(fas_p),
        .fwdb_sel_i(fbs_p), .fwd_data_i(fwd_p), .pc_plus_i(pcp_p), .pc_branch_i(pcb_p),
        .cal_result_i(cal_p), .write_back_o(wb), .kill_o(kill), .redirect_valid_o(rv),
        .redirect_pc_o(rpc), .upd_valid_o(uv), .upd_taken_o(ut), .upd_pc_o(upc),
        .branch_cnt_o(bcnt), .mispred_cnt_o(mcnt)
    );

    // Per-lane stimulus
    logic [1:0]      v, pt, lk;
    logic [2:0]      op  [LANES];
    logic [31:0]     sa  [LANES], sb [LANES], pp [LANES], pb [LANES], cr [LANES];
    logic [1:0]      fas [LANES], fbs [LANES];
    logic [31:0]     fd  [NFWD];

    // Reference state
    bit          m_known = 0, m_sq;
    bit          m_rv, m_uv, m_ut;
    logic [31:0] m_rpc, m_upc;
    int          m_bc, m_mc;
    int          n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] own);
        if (sel >= 1 && sel <= NFWD) return fd[sel-1];
        return own;
    endfunction

    function automatic bit br_taken(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return $signed(a) < $signed(b);
            3'd4: return $signed(a) >= $signed(b);
            3'd5: return a < b;
            3'd6: return a >= b;
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle();
        rst = 0; stall = 0; v = '0; pt = '0; lk = '0;
        for (int i = 0; i < LANES; i++) begin
            op[i] = '0; sa[i] = '0; sb[i] = '0; pp[i] = '0; pb[i] = '0; cr[i] = '0;
            fas[i] = '0; fbs[i] = '0;
        end
        for (int k = 0; k < NFWD; k++) fd[k] = '0;
    endtask

    task automatic settle();
        valid_p = v; pred_p = pt; link_p = lk;
        for (int i = 0; i < LANES; i++) begin
            op_p[i*3 +: 3] = op[i];
            srca_p[i*32 +: 32] = sa[i]; srcb_p[i*32 +: 32] = sb[i];
            pcp_p[i*32 +: 32] = pp[i];  pcb_p[i*32 +: 32] = pb[i];
            cal_p[i*32 +: 32] = cr[i];
            fas_p[i*2 +: 2] = fas[i];   fbs_p[i*2 +: 2] = fbs[i];
        end
        for (int k = 0; k < NFWD; k++) fwd_p[k*32 +: 32] = fd[k];
        #1;
    endtask

    // One clock: check current outputs against the model, then advance the model across the edge.
    task automatic step();
        bit          tk [LANES];
        bit          res [LANES];
        logic [31:0] apc [LANES];
        int          m, j, cnt;
        logic [1:0]  ekill;
        settle();
        m = -1; j = -1; cnt = 0; ekill = '0;
        for (int i = 0; i < LANES; i++) begin
            tk[i]  = br_taken(op[i], pick(fas[i], sa[i]), pick(fbs[i], sb[i]));
            res[i] = v[i] && op[i] != 0 && !m_sq;
            apc[i] = tk[i] ? pb[i] : pp[i];
        end
        for (int i = 0; i < LANES; i++) begin
            if (m >= 0) ekill[i] = 1'b1;
            else if (res[i]) begin
                cnt++;
                if (j < 0) j = i;
                if (tk[i] != pt[i]) m = i;
            end
        end
        chk("kill", kill, ekill);
        for (int i = 0; i < LANES; i++)
            chk("write_back", wb[i*32 +: 32], lk[i] ? pp[i] : cr[i]);
        if (m_known) begin
            chk("redirect_valid", rv, m_rv);
            if (m_rv) chk("redirect_pc", rpc, m_rpc);
            chk("upd_valid", uv, m_uv);
            if (m_uv) begin
                chk("upd_taken", ut, m_ut);
                chk("upd_pc", upc, m_upc);
            end
            chk("branch_cnt", bcnt, m_bc);
            chk("mispred_cnt", mcnt, m_mc);
        end
        @(posedge clk);
        if (rst) begin
            m_known = 1; m_sq = 0; m_rv = 0; m_uv = 0; m_ut = 0;
            m_rpc = 0; m_upc = 0; m_bc = 0; m_mc = 0;
        end else if (!stall) begin
            m_rv = (m >= 0);
            if (m >= 0) m_rpc = apc[m];
            m_uv = (j >= 0);
            if (j >= 0) begin
                m_ut  = tk[j];
                m_upc = pp[j] - 32'd4;
            end
            m_bc = (m_bc + cnt > CMAX) ? CMAX : m_bc + cnt;
            if (m >= 0 && m_mc < CMAX) m_mc++;
            m_sq = m_sq ? 1'b0 : (m >= 0);
        end
        @(negedge clk);
    endtask

    task automatic jal_mispredict(input logic [31:0] target);
        idle(); v = 2'b01; op[0] = 3'd7; pt[0] = 1'b0; pb[0] = target;
    endtask

    initial begin
        idle(); rst = 1; step();
        rst = 0;
        chk("rst_rv", rv, 0); chk("rst_uv", uv, 0); chk("rst_bc", bcnt, 0); chk("rst_mc", mcnt, 0);

        // beq through forwarding, predicted not-taken
        idle(); v = 2'b01; op[0] = 3'd1; sa[0] = 5; sb[0] = 99; fbs[0] = 2'd1; fd[0] = 5;
        pb[0] = 32'h100; pp[0] = 32'h8;
        step();
        chk("t1_rv", rv, 1); chk("t1_rpc", rpc, 32'h100); chk("t1_ut", ut, 1); chk("t1_mc", mcnt, 1);
        step();
        chk("t1_squash_rv", rv, 0); chk("t1_squash_bc", bcnt, 1);
        idle(); step();

        // signed vs unsigned compare on the same operands
        idle(); v = 2'b11; op[0] = 3'd3; op[1] = 3'd5; pt = 2'b11;
        sa[0] = 32'hFFFF_FFFF; sa[1] = 32'hFFFF_FFFF; sb[0] = 1; sb[1] = 1;
        pp[0] = 32'h108; pp[1] = 32'h208;
        settle(); chk("t2_kill", kill, 2'b00);
        step();
        chk("t2_rpc", rpc, 32'h208); chk("t2_bc", bcnt, 3); chk("t2_upc", upc, 32'h104);
        idle(); step();

        // both lanes mispredict: oldest wins, lane 1 killed
        idle(); v = 2'b11; op[0] = 3'd1; sa[0] = 1; sb[0] = 2; pt = 2'b01; pp[0] = 32'h300;
        op[1] = 3'd7; pb[1] = 32'h500;
        settle(); chk("t3_kill", kill, 2'b10);
        step();
        chk("t3_rpc", rpc, 32'h300); chk("t3_bc", bcnt, 4);
        idle(); step();

        // stall across the resolving edge, then across the pulse
        jal_mispredict(32'h600); stall = 1;
        repeat (3) begin step(); chk("t4_hold_rv", rv, 0); chk("t4_hold_bc", bcnt, 4); end
        stall = 0; step();
        chk("t4_rv", rv, 1); chk("t4_rpc", rpc, 32'h600);
        idle(); stall = 1;
        repeat (3) begin step(); chk("t4_keep_rv", rv, 1); end
        stall = 0; step(); chk("t4_after_rv", rv, 0);

        // reset while in SQUASH
        jal_mispredict(32'h680); step();
        idle(); rst = 1; step();
        chk("t5_rv", rv, 0); chk("t5_bc", bcnt, 0); chk("t5_mc", mcnt, 0); chk("t5_uv", uv, 0);
        jal_mispredict(32'h700); step();
        chk("t5_rv2", rv, 1); chk("t5_rpc", rpc, 32'h700); chk("t5_mc2", mcnt, 1);
        idle(); step();

        // mispredict counter saturation
        repeat (17) begin jal_mispredict(32'h800); step(); idle(); step(); end
        chk("t6_mc_sat", mcnt, CMAX);

        // link write-back on a killed lane
        idle(); v = 2'b11; op[0] = 3'd7; pb[0] = 32'h900; lk = 2'b10; pp[1] = 32'h44; cr[1] = 32'h99;
        settle(); chk("t7_kill", kill, 2'b10); chk("t7_wb", wb[63:32], 32'h44);
        step(); idle(); step();

        repeat (3000) begin
            rst   = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 15);
            v  = 2'($urandom); pt = 2'($urandom); lk = 2'($urandom);
            for (int i = 0; i < LANES; i++) begin
                op[i]  = 3'($urandom);
                sa[i]  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
                sb[i]  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
                pp[i]  = $urandom; pb[i] = $urandom; cr[i] = $urandom;
                fas[i] = 2'($urandom); fbs[i] = 2'($urandom);
            end
            for (int k = 0; k < NFWD; k++)
                fd[k] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
            step();
        end
        idle(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ma.md
Name: branch_resolve_ma

Overview:
- Multi-lane successor to the single-slot MA-stage branch resolver of the VLIW core.
- Per lane: forwards operands from NFWD writeback sources, evaluates an extended compare set, and computes the actual target and the link write-back value.
- Across lanes: detects the oldest mispredict, kills younger lanes, and registers a one-cycle redirect with a post-redirect squash window, predictor-update port and performance counters.

Parameters:
- LANES, 2, issue slots resolved per cycle (1..4); lane 0 is oldest.
- XLEN, 32, datapath/PC width.
- NFWD, 2, number of forwarding sources.
- SELW, 2, forward-select width; 2^SELW > NFWD.
- CNTW, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_i  in  1  pipeline hold; freezes all state and registered outputs
- valid_i  in  LANES  lane carries a live instruction
- op_i  in  3*LANES  000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu, 111 jal/jalr (always taken)
- link_i  in  LANES  write pc_plus instead of cal_result
- pred_taken_i  in  LANES  front-end prediction
- srca_i, srcb_i  in  XLEN*LANES  register-read operands
- fwda_sel_i, fwdb_sel_i  in  SELW*LANES  0 = own operand; k in 1..NFWD = fwd_data_i[k-1]; >NFWD = own operand
- fwd_data_i  in  XLEN*NFWD  writeback data (W3, W4, ...)
- pc_plus_i, pc_branch_i, cal_result_i  in  XLEN*LANES  fall-through PC, taken target, ALU result
- write_back_o  out  XLEN*LANES  combinational: link ? pc_plus : cal_result
- kill_o  out  LANES  combinational: lanes younger than the mispredicting lane
- redirect_valid_o  out  1  registered one-cycle pulse
- redirect_pc_o  out  XLEN  registered corrected PC
- upd_valid_o, upd_taken_o  out  1 each  registered predictor update
- upd_pc_o  out  XLEN  registered; pc_plus - 4 of the updated branch
- branch_cnt_o, mispred_cnt_o  out  CNTW each  saturating counters

Behaviour:
- Reset (rst high at a clock edge): all registered outputs 0, counters 0, FSM to RUN. Reset overrides stall_i.
- Lane valid for resolution: valid_i && op != 000 && FSM == RUN.
  - blt/bge compare signed; bltu/bgeu unsigned; beq/bne on full XLEN.
  - taken = compare result, or 1 for op 111.
  - actual_pc = taken ? pc_branch : pc_plus.
  - mispredict = taken != pred_taken.
- Priority:
  - The lowest-index mispredicting lane m is selected.
  - kill_o sets bits m+1..LANES-1.
  - Lanes above m are not counted and do not update the predictor.
  - kill_o is 0 when no mispredict is found or FSM != RUN.
- Registered at the next edge, when !stall_i:
  - redirect_valid_o = any mispredict; redirect_pc_o = actual_pc[m].
  - upd_* reports the oldest resolved branch lane (lowest index). If lanes 0 and 1 both resolve and neither mispredicts, lane 0 is reported.
- FSM:
  - RUN -> SQUASH on a registered redirect.
  - SQUASH ignores valid_i for exactly one cycle (wrong-path slot), then returns to RUN.
  - Both states hold while stall_i is high.
  - During stall_i, redirect_valid_o and upd_valid_o keep their values; there is no double pulse because the consumer also stalls.
- Counters:
  - branch_cnt_o += number of resolved, non-killed lanes.
  - mispred_cnt_o += 1 per redirect.
  - Both saturate at 2^CNTW-1 with no wrap, and both are frozen during stall.
- write_back_o is purely combinational and is independent of FSM, stall and kill; the consumer masks it with kill_o.
- Latency: redirect visible 1 cycle after the resolving cycle; a single bubble (SQUASH) follows.

Decomposition:
- Shared package holds:
  - op encodings OP_NONE..OP_JMP
  - FSM state constants RUN = 0, SQUASH = 1
  - forward-select value 0 = OWN
- One sub-module, branch_lane_eval:
  - forward muxes, compare, taken/actual_pc/mispredict for one lane
  - instantiated LANES times via generate
- Top module owns priority, kill mask, FSM, output registers and counters.

Test Plan:
- LANES=2. Lane0 beq, srca=5, srcb from fwd sel 1 with fwd_data[0]=5, pred_taken=0, pc_branch=0x100.
  - Required: next cycle redirect_valid_o=1, redirect_pc_o=0x100, upd_taken_o=1, mispred_cnt_o=1.
  - The cycle after: lane inputs ignored, redirect_valid_o=0.
- Lane0 blt, srca=0xFFFFFFFF, srcb=1, pred=1; lane1 bltu with same operands, pred=1.
  - Required: lane0 correct (signed taken); lane1 mispredicts (unsigned not taken).
  - Required: redirect_pc_o = lane1 pc_plus, kill_o=00, branch_cnt_o += 2.
- Both lanes mispredict.
  - Required: redirect_pc_o from lane0, kill_o=10 in the resolving cycle, branch_cnt_o += 1.
- Mispredict with stall_i held high for 3 cycles at the resolving edge.
  - Required: no register change until stall_i drops, then a single redirect pulse.
  - Required: redirect_valid_o stays high for the whole stall if asserted before it.
- Reset asserted while in SQUASH with counters nonzero.
  - Required: after one edge, all outputs 0, FSM RUN; the next valid branch is resolved normally.
- Preload mispred_cnt_o to 2^CNTW-1 (CNTW=4: 15), then force a further mispredict.
  - Required: counter stays at 15.
- Separately, link_i=1 with pc_plus=0x44.
  - Required: write_back_o=0x44 combinationally, regardless of kill.
